lp805x_sfr_chan: RTL and testbench



---
 rtl/lp805x_sfr_chan.sv | 114 +++++++++++
 tb/tb_lp805x_sfr_chan.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/lp805x_sfr_chan.sv
// lp805x SFR bus channel: request FIFO with head decode, response FIFO.
// Optional build macro: LP805X_SFR_TRISTATE_EN (tri-state idle read bus).
module lp805x_sfr_chan #(
   parameter int FIFO_DEPTH = 2,
   parameter int ADDR_W     = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [28:0] sfr_bus,
   input  logic        sfr_put,
   output logic        sfr_wrdy,
   input  logic        dec_get,
   output logic        dec_vld,
   output logic        wr,
   output logic        rd,
   output logic        wr_bit,
   output logic        rd_bit,
   output logic [7:0]  wr_addr,
   output logic [7:0]  rd_addr,
   output logic [7:0]  data_in,
   output logic        bit_in,
   input  logic [7:0]  rsp_data,
   input  logic        rsp_bit,
   input  logic        rsp_load,
   output logic        rsp_wrdy,
   input  logic        sfr_get,
   output logic        sfr_rrdy,
   output logic [7:0]  data_out,
   output logic        bit_out
);

   localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

   logic [28:0]     req_mem [FIFO_DEPTH];
   logic [8:0]      rsp_mem [FIFO_DEPTH];
   logic [ADDR_W:0] req_wp;
   logic [ADDR_W:0] req_rp;
   logic [ADDR_W:0] rsp_wp;
   logic [ADDR_W:0] rsp_rp;
   logic            req_push;
   logic            req_pop;
   logic            rsp_push;
   logic            rsp_pop;
   logic [28:0]     req_head;
   logic [8:0]      rsp_head;

   // full: same slot, different lap; empty: pointers identical
   assign sfr_wrdy = !((req_wp[ADDR_W] != req_rp[ADDR_W]) &&
                       (req_wp[ADDR_W-1:0] == req_rp[ADDR_W-1:0]));
   assign dec_vld  = (req_wp != req_rp);
   assign rsp_wrdy = !((rsp_wp[ADDR_W] != rsp_rp[ADDR_W]) &&
                       (rsp_wp[ADDR_W-1:0] == rsp_rp[ADDR_W-1:0]));
   assign sfr_rrdy = (rsp_wp != rsp_rp);

   assign req_push = sfr_put  & sfr_wrdy;
   assign req_pop  = dec_get  & dec_vld;
   assign rsp_push = rsp_load & rsp_wrdy;
   assign rsp_pop  = sfr_get  & sfr_rrdy;

   assign req_head = req_mem[req_rp[ADDR_W-1:0]];
   assign rsp_head = rsp_mem[rsp_rp[ADDR_W-1:0]];

   // pointer registers; reset discards all stored entries
   always_ff @(posedge clk) begin
      if (!rst) begin
         req_wp <= '0;
         req_rp <= '0;
         rsp_wp <= '0;
         rsp_rp <= '0;
      end else begin
         if (req_push) req_wp <= req_wp + PTR_ONE;
         if (req_pop)  req_rp <= req_rp + PTR_ONE;
         if (rsp_push) rsp_wp <= rsp_wp + PTR_ONE;
         if (rsp_pop)  rsp_rp <= rsp_rp + PTR_ONE;
      end
   end

   // storage arrays; contents are don't-care until written
   always_ff @(posedge clk) begin
      if (rst && req_push) req_mem[req_wp[ADDR_W-1:0]] <= sfr_bus;
      if (rst && rsp_push) rsp_mem[rsp_wp[ADDR_W-1:0]] <= {rsp_data, rsp_bit};
   end

   // head-word decode, all fields quiet while the FIFO is empty
   always_comb begin
      wr      = 1'b0;
      rd      = 1'b0;
      wr_bit  = 1'b0;
      rd_bit  = 1'b0;
      wr_addr = 8'h00;
      rd_addr = 8'h00;
      data_in = 8'h00;
      bit_in  = 1'b0;
      if (dec_vld) begin
         wr      = req_head[28];
         rd      = req_head[27];
         wr_bit  = req_head[26];
         rd_bit  = req_head[25];
         wr_addr = req_head[24:17];
         rd_addr = req_head[16:9];
         data_in = req_head[8:1];
         bit_in  = req_head[0];
      end
   end

`ifdef LP805X_SFR_TRISTATE_EN
   assign data_out = sfr_rrdy ? rsp_head[8:1] : 8'hzz;
   assign bit_out  = sfr_rrdy ? rsp_head[0]   : 1'bz;
`else
   assign data_out = sfr_rrdy ? rsp_head[8:1] : 8'h00;
   assign bit_out  = sfr_rrdy ? rsp_head[0]   : 1'b0;
`endif

endmodule

// File: tb/tb_lp805x_sfr_chan.sv
// Directed self-checking bench for lp805x_sfr_chan.
// Expected values are hand-computed from the request/response layouts.
module tb_lp805x_sfr_chan;

   logic        clk = 1'b0;
   logic        rst;
   logic [28:0] sfr_bus;
   logic        sfr_put;
   logic        sfr_wrdy;
   logic        dec_get;
   logic        dec_vld;
   logic        wr;
   logic        rd;
   logic        wr_bit;
   logic        rd_bit;
   logic [7:0]  wr_addr;
   logic [7:0]  rd_addr;
   logic [7:0]  data_in;
   logic        bit_in;
   logic [7:0]  rsp_data;
   logic        rsp_bit;
   logic        rsp_load;
   logic        rsp_wrdy;
   logic        sfr_get;
   logic        sfr_rrdy;
   logic [7:0]  data_out;
   logic        bit_out;

   int n_checks = 0;
   int n_errors = 0;
   logic [7:0] idle_byte;
   logic       idle_bit;

   lp805x_sfr_chan #(.FIFO_DEPTH(2), .ADDR_W(1)) dut (
      .clk(clk), .rst(rst),
      .sfr_bus(sfr_bus), .sfr_put(sfr_put), .sfr_wrdy(sfr_wrdy),
      .dec_get(dec_get), .dec_vld(dec_vld),
      .wr(wr), .rd(rd), .wr_bit(wr_bit), .rd_bit(rd_bit),
      .wr_addr(wr_addr), .rd_addr(rd_addr),
      .data_in(data_in), .bit_in(bit_in),
      .rsp_data(rsp_data), .rsp_bit(rsp_bit), .rsp_load(rsp_load),
      .rsp_wrdy(rsp_wrdy), .sfr_get(sfr_get), .sfr_rrdy(sfr_rrdy),
      .data_out(data_out), .bit_out(bit_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [28:0] head_word();
      return {wr, rd, wr_bit, rd_bit, wr_addr, rd_addr, data_in, bit_in};
   endfunction

   function automatic logic [28:0] stream_word(input int i);
      logic [31:0] w;
      w = 32'h0ABC_0000 + 32'(i) * 32'h0111_1111;
      return w[28:0];
   endfunction

   task automatic push_req(input logic [28:0] w);
      sfr_bus = w;
      sfr_put = 1'b1;
      step();
      sfr_put = 1'b0;
   endtask

   task automatic pop_req();
      dec_get = 1'b1;
      step();
      dec_get = 1'b0;
   endtask

   task automatic push_rsp(input logic [7:0] d, input logic b);
      rsp_data = d;
      rsp_bit  = b;
      rsp_load = 1'b1;
      step();
      rsp_load = 1'b0;
   endtask

   task automatic pop_rsp();
      sfr_get = 1'b1;
      step();
      sfr_get = 1'b0;
   endtask

   initial begin
`ifdef LP805X_SFR_TRISTATE_EN
      idle_byte = 8'hzz;
      idle_bit  = 1'bz;
`else
      idle_byte = 8'h00;
      idle_bit  = 1'b0;
`endif
      rst = 1'b0;
      sfr_bus = '0; sfr_put = 0; dec_get = 0;
      rsp_data = '0; rsp_bit = 0; rsp_load = 0; sfr_get = 0;
      step();
      step();
      rst = 1'b1;

      check("rst_sfr_wrdy", 32'(sfr_wrdy), 32'd1);
      check("rst_rsp_wrdy", 32'(rsp_wrdy), 32'd1);
      check("rst_dec_vld", 32'(dec_vld), 32'd0);
      check("rst_sfr_rrdy", 32'(sfr_rrdy), 32'd0);
      check("rst_decode", 32'(head_word()), 32'd0);
      check("rst_data_out", 32'(data_out), 32'(idle_byte));
      check("rst_bit_out", 32'(bit_out), 32'(idle_bit));

      push_req(29'h1F5A_5A5B);
      check("dec_vld", 32'(dec_vld), 32'd1);
      check("dec_strobes", {28'd0, wr, rd, wr_bit, rd_bit}, 32'hF);
      check("dec_wr_addr", 32'(wr_addr), 32'hAD);
      check("dec_rd_addr", 32'(rd_addr), 32'h2D);
      check("dec_data_in", 32'(data_in), 32'h2D);
      check("dec_bit_in", 32'(bit_in), 32'd1);
      pop_req();
      check("pop_dec_vld", 32'(dec_vld), 32'd0);
      check("pop_decode_zero", 32'(head_word()), 32'd0);

      push_req(29'h0000_1111);
      check("fill1_wrdy", 32'(sfr_wrdy), 32'd1);
      push_req(29'h0222_2222);
      check("fill2_wrdy", 32'(sfr_wrdy), 32'd0);
      push_req(29'h1333_3333);
      check("drop_wrdy", 32'(sfr_wrdy), 32'd0);
      check("fifo_head1", 32'(head_word()), 32'h0000_1111);
      pop_req();
      check("fifo_head2", 32'(head_word()), 32'h0222_2222);
      pop_req();
      check("fifo_empty", 32'(dec_vld), 32'd0);

      push_req(29'h0AAA_AAAA);
      push_req(29'h1555_5555);
      sfr_bus = 29'h1CCC_CCCC;
      sfr_put = 1'b1;
      dec_get = 1'b1;
      step();
      sfr_put = 1'b0;
      dec_get = 1'b0;
      check("fullpp_head", 32'(head_word()), 32'h1555_5555);
      check("fullpp_wrdy", 32'(sfr_wrdy), 32'd1);
      pop_req();
      check("fullpp_occ1", 32'(dec_vld), 32'd0);

      push_rsp(8'hC3, 1'b1);
      check("rsp_rrdy", 32'(sfr_rrdy), 32'd1);
      check("rsp_data_out", 32'(data_out), 32'hC3);
      check("rsp_bit_out", 32'(bit_out), 32'd1);
      pop_rsp();
      check("rsp_empty", 32'(sfr_rrdy), 32'd0);
      check("rsp_idle_data", 32'(data_out), 32'(idle_byte));
      check("rsp_idle_bit", 32'(bit_out), 32'(idle_bit));

      push_rsp(8'h5A, 1'b0);
      push_rsp(8'hA5, 1'b1);
      check("rsp_full", 32'(rsp_wrdy), 32'd0);
      push_rsp(8'hFF, 1'b1);
      check("rsp_head1", {23'd0, data_out, bit_out}, {23'd0, 8'h5A, 1'b0});
      pop_rsp();
      check("rsp_head2", {23'd0, data_out, bit_out}, {23'd0, 8'hA5, 1'b1});
      pop_rsp();
      check("rsp_drained", 32'(sfr_rrdy), 32'd0);

      push_req(stream_word(0));
      for (int i = 1; i < 10; i++) begin
         check($sformatf("stream_%0d", i - 1), 32'(head_word()),
               32'(stream_word(i - 1)));
         sfr_bus = stream_word(i);
         sfr_put = 1'b1;
         dec_get = 1'b1;
         step();
      end
      sfr_put = 1'b0;
      dec_get = 1'b0;
      check("stream_9", 32'(head_word()), 32'(stream_word(9)));
      pop_req();
      check("stream_empty", 32'(dec_vld), 32'd0);

      push_req(29'h0123_4567);
      push_req(29'h0765_4321);
      push_rsp(8'h77, 1'b1);
      rst = 1'b0;
      step();
      check("mrst_sfr_wrdy", 32'(sfr_wrdy), 32'd1);
      check("mrst_rsp_wrdy", 32'(rsp_wrdy), 32'd1);
      check("mrst_dec_vld", 32'(dec_vld), 32'd0);
      check("mrst_sfr_rrdy", 32'(sfr_rrdy), 32'd0);
      rst = 1'b1;
      step();
      check("post_rst_dec_vld", 32'(dec_vld), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
